// File: rtl/volatility_estimator.sv
// Rolling-window population variance of a mid-price stream, one sample per cycle.
// Three stages: running sums, scaled variance numerator, normalise and saturate.
//
// state  | meaning
// S_FILL | fewer than WINDOW samples since reset/clear, no output produced
// S_RUN  | window full, every accepted sample yields a result two edges later
module volatility_estimator #(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW      = 16,
  parameter int LOG2_WINDOW = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_price,
  input  logic                  i_price_valid,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_volatility,
  output logic                  o_data_valid
);

  localparam int SUM_W = DATA_WIDTH + LOG2_WINDOW;
  localparam int SQ_W  = 2*DATA_WIDTH + LOG2_WINDOW;
  localparam int D_W   = 2*DATA_WIDTH + 2*LOG2_WINDOW;
  localparam int CNT_W = LOG2_WINDOW + 1;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   buf_mem [WINDOW];
  logic [LOG2_WINDOW-1:0]  wptr;
  logic [CNT_W-1:0]        fill_cnt;
  logic [SUM_W-1:0]        sum;
  logic [SQ_W-1:0]         sumsq;
  logic                    valid0, valid1;
  logic [D_W-1:0]          d_reg;

  logic                    accept, full_after;
  logic [DATA_WIDTH-1:0]   old;
  logic [2*DATA_WIDTH-1:0] p_ext, old_ext, p_sq, old_sq;
  logic [SUM_W-1:0]        sum_nxt;
  logic [SQ_W-1:0]         sumsq_nxt;
  logic [D_W-1:0]          sq_sh, sum_ext, sum_sq, d_nxt, v;
  logic [DATA_WIDTH-1:0]   v_sat;

  assign accept     = i_price_valid & ~i_clear;
  assign full_after = (state == S_RUN) || (fill_cnt == CNT_W'(WINDOW-1));

  // Entries are zero until overwritten, so FILL needs no special-case subtraction.
  assign old       = buf_mem[wptr];
  assign p_ext     = {{DATA_WIDTH{1'b0}}, i_price};
  assign old_ext   = {{DATA_WIDTH{1'b0}}, old};
  assign p_sq      = p_ext * p_ext;
  assign old_sq    = old_ext * old_ext;
  assign sum_nxt   = sum + {{LOG2_WINDOW{1'b0}}, i_price} - {{LOG2_WINDOW{1'b0}}, old};
  assign sumsq_nxt = sumsq + {{LOG2_WINDOW{1'b0}}, p_sq} - {{LOG2_WINDOW{1'b0}}, old_sq};

  // N*sum(x^2) - (sum x)^2 is never negative; the compare is only a guard.
  assign sq_sh   = {sumsq, {LOG2_WINDOW{1'b0}}};
  assign sum_ext = {{(D_W-SUM_W){1'b0}}, sum};
  assign sum_sq  = sum_ext * sum_ext;
  assign d_nxt   = (sq_sh >= sum_sq) ? (sq_sh - sum_sq) : '0;

  assign v     = d_reg >> (2*LOG2_WINDOW);
  assign v_sat = (|v[D_W-1:DATA_WIDTH]) ? '1 : v[DATA_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear)                  state_nxt = S_FILL;
    else if (accept && full_after) state_nxt = S_RUN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WINDOW; i++) buf_mem[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < WINDOW; i++) buf_mem[i] <= '0;
    end else if (accept) begin
      buf_mem[wptr] <= i_price;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr         <= '0;
      fill_cnt     <= '0;
      sum          <= '0;
      sumsq        <= '0;
      valid0       <= 1'b0;
      valid1       <= 1'b0;
      d_reg        <= '0;
      o_volatility <= '0;
      o_data_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        wptr     <= '0;
        fill_cnt <= '0;
        sum      <= '0;
        sumsq    <= '0;
        valid0   <= 1'b0;
      end else begin
        valid0 <= accept && full_after;
        if (accept) begin
          wptr  <= wptr + 1'b1;
          sum   <= sum_nxt;
          sumsq <= sumsq_nxt;
          if (fill_cnt != CNT_W'(WINDOW)) fill_cnt <= fill_cnt + 1'b1;
        end
      end

      valid1 <= valid0 & ~i_clear;
      if (valid0) d_reg <= d_nxt;

      o_data_valid <= valid1 & ~i_clear;
      if (valid1 && !i_clear) o_volatility <= v_sat;
    end
  end

endmodule
